// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage of the five-stage MIPS pipeline.
//
// Owns the program counter, issues one word fetch at a time over a req/ack
// instruction-memory port, and buffers returned words in a 2-entry FIFO whose
// head feeds the decode stage. Honours a stall from pipeline control and a
// flush/redirect from branch resolution.
//
// Optional feature macro: INST_FETCH_BYPASS_EN
//   defined   : an acked word with an empty FIFO is forwarded combinationally
//               to pc_o/inst_o/valid_o (0-cycle fetch-to-decode latency).
//   undefined : outputs come only from FIFO registers (1-cycle latency).
//
// Ports:
//   clk           in   pipeline clock, rising edge
//   rst           in   asynchronous reset, active low
//   inst_req_o    out  fetch request (registered)
//   inst_addr_o   out  fetch address (registered, stable until ack)
//   inst_ack_i    in   memory completes the pending request this cycle
//   inst_rdata_i  in   instruction word, valid with inst_ack_i
//   stall_i       in   decode cannot accept; head is held
//   flush_i       in   redirect: discard buffered and in-flight words
//   flush_pc_i    in   redirect target (bits [1:0] forced to 0)
//   valid_o       out  pc_o/inst_o hold a real instruction
//   pc_o          out  address of head instruction, 0 when not valid
//   inst_o        out  head instruction, 0 (NOP) when not valid
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        inst_req_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_ack_i,
   input  logic [31:0] inst_rdata_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [1:0]  count_q, count_d;
   // FIFO entry 0 is always the head; entry 1 is the second word.
   logic [31:0] pc0_q, pc0_d, inst0_q, inst0_d;
   logic [31:0] pc1_q, pc1_d, inst1_q, inst1_d;

   logic        fifo_vld;
   logic        ack_req;
   logic        bypass;
   logic        push;
   logic        pop;
   logic [31:0] flush_tgt;
   logic [31:0] next_seq;

   assign fifo_vld  = (count_q != 2'd0);
   assign ack_req   = (state_q == REQ) && inst_ack_i;
   assign flush_tgt = flush_pc_i & 32'hFFFF_FFFC;
   // While in REQ fetch_pc and req_addr always name the same word.
   assign next_seq  = req_addr_q + 32'd4;

`ifdef INST_FETCH_BYPASS_EN
   assign bypass = (count_q == 2'd0) && ack_req && !flush_i;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed word taken by decode in the same cycle never enters the FIFO.
   assign push = ack_req && !flush_i && !(bypass && !stall_i);
   assign pop  = fifo_vld && !stall_i && !flush_i;

   always_comb begin
      count_d = count_q;
      if (flush_i)
         count_d = 2'd0;
      else if (push && !pop)
         count_d = count_q + 2'd1;
      else if (pop && !push)
         count_d = count_q - 2'd1;
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      case (state_q)
         IDLE: begin
            if (flush_i) begin
               state_d    = REQ;
               req_addr_d = flush_tgt;
            end else if (count_d < 2'd2) begin
               state_d    = REQ;
               req_addr_d = fetch_pc_q;
            end
         end
         REQ: begin
            if (flush_i) begin
               // Without an ack the address must stay put until memory answers.
               if (inst_ack_i) req_addr_d = flush_tgt;
               else            state_d    = DRAIN;
            end else if (inst_ack_i) begin
               fetch_pc_d = next_seq;
               if (count_d < 2'd2) req_addr_d = next_seq;
               else                state_d    = IDLE;
            end
         end
         DRAIN: begin
            if (inst_ack_i) begin
               state_d    = REQ;
               req_addr_d = flush_i ? flush_tgt : fetch_pc_q;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush_i) fetch_pc_d = flush_tgt;
   end

   assign req_d = (state_d != IDLE);

   always_comb begin
      pc0_d   = pc0_q;
      inst0_d = inst0_q;
      pc1_d   = pc1_q;
      inst1_d = inst1_q;
      if (pop) begin
         pc0_d   = pc1_q;
         inst0_d = inst1_q;
      end
      if (push) begin
         // Write slot is count - pop; push only happens with count <= 1.
         if ((count_q == 2'd0) || pop) begin
            pc0_d   = req_addr_q;
            inst0_d = inst_rdata_i;
         end else begin
            pc1_d   = req_addr_q;
            inst1_d = inst_rdata_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
         count_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
         count_q    <= count_d;
      end
   end

   // FIFO payload needs no reset: the output mux gates it with count.
   always_ff @(posedge clk) begin
      pc0_q   <= pc0_d;
      inst0_q <= inst0_d;
      pc1_q   <= pc1_d;
      inst1_q <= inst1_d;
   end

   assign inst_req_o  = req_q;
   assign inst_addr_o = req_addr_q;

   always_comb begin
      valid_o = 1'b0;
      pc_o    = 32'h0;
      inst_o  = 32'h0;
      if (fifo_vld) begin
         valid_o = 1'b1;
         pc_o    = pc0_q;
         inst_o  = inst0_q;
      end else if (bypass) begin
         valid_o = 1'b1;
         pc_o    = req_addr_q;
         inst_o  = inst_rdata_i;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic [31:0] flush_pc;
   logic        use_tie;
   logic        ack_man;
   logic        fixed_en;
   logic [31:0] fixed_word;

   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;
   logic        valid;
   logic [31:0] pc;
   logic [31:0] inst;

   logic        req2;
   logic [31:0] addr2;
   logic        ack2;
   logic [31:0] rdata2;
   logic        valid2;
   logic [31:0] pc2;
   logic [31:0] inst2;

   int checks;
   int failures;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   assign ack    = use_tie ? req : ack_man;
   assign rdata  = fixed_en ? fixed_word : word_of(addr);
   assign ack2   = req2;
   assign rdata2 = word_of(addr2);

   inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .inst_req_o   (req),
      .inst_addr_o  (addr),
      .inst_ack_i   (ack),
      .inst_rdata_i (rdata),
      .stall_i      (stall),
      .flush_i      (flush),
      .flush_pc_i   (flush_pc),
      .valid_o      (valid),
      .pc_o         (pc),
      .inst_o       (inst)
   );

   inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk          (clk),
      .rst          (rst),
      .inst_req_o   (req2),
      .inst_addr_o  (addr2),
      .inst_ack_i   (ack2),
      .inst_rdata_i (rdata2),
      .stall_i      (1'b0),
      .flush_i      (1'b0),
      .flush_pc_i   (32'h0),
      .valid_o      (valid2),
      .pc_o         (pc2),
      .inst_o       (inst2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [31:0] wrap_addr [1:3];
      logic [31:0] wrap_pc   [1:3];
      checks     = 0;
      failures   = 0;
      rst        = 1'b0;
      stall      = 1'b0;
      flush      = 1'b0;
      flush_pc   = 32'h0;
      use_tie    = 1'b1;
      ack_man    = 1'b0;
      fixed_en   = 1'b0;
      fixed_word = 32'h0;
      wrap_addr[1] = 32'hFFFF_FFFC; wrap_pc[1] = 32'hFFFF_FFF8;
      wrap_addr[2] = 32'h0000_0000; wrap_pc[2] = 32'hFFFF_FFFC;
      wrap_addr[3] = 32'h0000_0004; wrap_pc[3] = 32'h0000_0000;

      // Reset state
      tick();
      chk("rst_req",   {31'h0, req},   32'h0);
      chk("rst_addr",  addr,           32'h0);
      chk("rst_valid", {31'h0, valid}, 32'h0);
      chk("rst_pc",    pc,             32'h0);
      chk("rst_inst",  inst,           32'h0);
      chk("rst_addr2", addr2,          32'hFFFF_FFF8);
      tick();
      rst = 1'b1;

      // Zero-wait streaming: first request on the first edge after release
      tick();
      chk("s_req0",   {31'h0, req},   32'h1);
      chk("s_addr0",  addr,           32'h0);
      chk("s_valid0", {31'h0, valid}, 32'h0);
      chk("w_addr0",  addr2,          32'hFFFF_FFF8);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("s_addr",   addr,             32'(4 * i));
         chk("s_valid",  {31'h0, valid},   32'h1);
         chk("s_pc",     pc,               32'(4 * (i - 1)));
         chk("s_inst",   inst,             word_of(32'(4 * (i - 1))));
         chk("w_addr",   addr2,            wrap_addr[i]);
         chk("w_pc",     pc2,              wrap_pc[i]);
         chk("w_inst",   inst2,            word_of(wrap_pc[i]));
         chk("w_valid",  {31'h0, valid2},  32'h1);
      end

      // Stall for five cycles: head frozen at 8, FIFO fills, request drops
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("st_pc",    pc,             32'h8);
         chk("st_inst",  inst,           word_of(32'h8));
         chk("st_valid", {31'h0, valid}, 32'h1);
         chk("st_req",   {31'h0, req},   32'h0);
      end
      stall = 1'b0;
      tick();
      chk("rel_pc0",   pc,           32'hC);
      chk("rel_inst0", inst,         word_of(32'hC));
      chk("rel_req",   {31'h0, req}, 32'h1);
      chk("rel_addr",  addr,         32'h10);
      tick();
      chk("rel_pc1",   pc,           32'h10);
      chk("rel_inst1", inst,         word_of(32'h10));
      chk("rel_addr1", addr,         32'h14);

      // Slow memory; flush while the request to 0x14 is outstanding
      use_tie = 1'b0;
      ack_man = 1'b0;
      tick();
      chk("sl_valid", {31'h0, valid}, 32'h0);
      chk("sl_pc",    pc,             32'h0);
      chk("sl_addr",  addr,           32'h14);
      flush    = 1'b1;
      flush_pc = 32'h0000_0103;
      tick();
      flush = 1'b0;
      chk("fl_addr_hold", addr,           32'h14);
      chk("fl_req",       {31'h0, req},   32'h1);
      chk("fl_valid",     {31'h0, valid}, 32'h0);
      tick();
      chk("dr_addr_hold", addr,           32'h14);
      ack_man = 1'b1;
      tick();
      ack_man = 1'b0;
      chk("dr_redirect",  addr,           32'h100);
      chk("dr_valid",     {31'h0, valid}, 32'h0);
      tick();
      chk("dr_no_stale",  {31'h0, valid}, 32'h0);
      ack_man = 1'b1;
      tick();
      ack_man = 1'b0;
      chk("tg_valid", {31'h0, valid}, 32'h1);
      chk("tg_pc",    pc,             32'h100);
      chk("tg_inst",  inst,           word_of(32'h100));
      chk("tg_addr",  addr,           32'h104);

      // Flush together with an ack and a pop while count is 1
      ack_man  = 1'b1;
      flush    = 1'b1;
      flush_pc = 32'h0000_0200;
      tick();
      ack_man = 1'b0;
      flush   = 1'b0;
      #1;
      chk("fa_valid", {31'h0, valid}, 32'h0);
      chk("fa_pc",    pc,             32'h0);
      chk("fa_inst",  inst,           32'h0);
      chk("fa_addr",  addr,           32'h200);
      tick();
      chk("fa_empty", {31'h0, valid}, 32'h0);

      // Word 0x3421_0001 acked with an empty FIFO
      fixed_en   = 1'b1;
      fixed_word = 32'h3421_0001;
      use_tie    = 1'b1;
      #1;
`ifdef INST_FETCH_BYPASS_EN
      chk("by_valid", {31'h0, valid}, 32'h1);
      chk("by_inst",  inst,           32'h3421_0001);
      chk("by_pc",    pc,             32'h200);
`else
      chk("by_valid", {31'h0, valid}, 32'h0);
      chk("by_inst",  inst,           32'h0);
`endif
      tick();
      chk("by_inst1",  inst,           32'h3421_0001);
      chk("by_valid1", {31'h0, valid}, 32'h1);
`ifdef INST_FETCH_BYPASS_EN
      chk("by_pc1",    pc,             32'h204);
`else
      chk("by_pc1",    pc,             32'h200);
`endif

      // Asynchronous reset in the middle of a transaction
      #3;
      rst = 1'b0;
      #1;
      chk("ar_req",   {31'h0, req},   32'h0);
      chk("ar_addr",  addr,           32'h0);
      chk("ar_valid", {31'h0, valid}, 32'h0);
      chk("ar_pc",    pc,             32'h0);
      chk("ar_inst",  inst,           32'h0);
      chk("ar_req2",  {31'h0, req2},  32'h0);
      chk("ar_addr2", addr2,          32'hFFFF_FFF8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
